hls_deadlock_report_collector: RTL and testbench

HLS_DEADLOCK_REPORT_COLLECTOR -- requirements
Module: hls_deadlock_report_collector

---
 rtl/hls_deadlock_report_collector.sv | 170 +++++++++++++++++
 tb/tb_hls_deadlock_report_collector.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hls_deadlock_report_collector.sv
// Confirms deadlock-monitor block runs that last THRESHOLD sampled cycles.
// Each confirmed episode is queued as a timestamped report in a small FIFO.
module hls_deadlock_report_collector #(
  parameter int THRESHOLD  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_WIDTH   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  block,
  input  logic [3:0]            axis_block_info,
  output logic                  report_valid,
  input  logic                  report_ready,
  output logic [4+TS_WIDTH-1:0] report_data,
  output logic                  deadlock_active,
  output logic                  overflow,
  output logic [15:0]           event_count,
  input  logic                  clear
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          DW       = 4 + TS_WIDTH;
  localparam logic [15:0] CNT_LAST = 16'(THRESHOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PENDING   = 2'd1,
    S_CONFIRMED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [3:0]          info_q, info_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]       mem_q [FIFO_DEPTH];
  logic [DW-1:0]       mem_d [FIFO_DEPTH];
  logic                overflow_q, overflow_d;
  logic [15:0]         event_count_q, event_count_d;
  logic                push_s, pop_s, push_ok_s, drop_s, empty_s, full_s;

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      info_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      info_q  <= info_d;
    end
  end

  // next-state: a changed block code restarts the run rather than aborting it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    info_d  = info_q;
    push_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (block) begin
          state_d = S_PENDING;
          cnt_d   = 16'd1;
          info_d  = axis_block_info;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PENDING: begin
        if (!block) begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
        end else if (axis_block_info != info_q) begin
          cnt_d  = 16'd1;
          info_d = axis_block_info;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_CONFIRMED;
          cnt_d   = 16'd0;
          push_s  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_CONFIRMED: begin
        if (!block) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CONFIRMED;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // outputs
  always_comb begin
    deadlock_active = (state_q == S_CONFIRMED);
    report_valid    = !empty_s;
    overflow        = overflow_q;
    event_count     = event_count_q;
    if (empty_s) begin
      report_data = {DW{1'b0}};
    end else begin
      report_data = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  // FIFO bookkeeping; a pop frees the slot for a push on the same edge
  always_comb begin
    empty_s   = (wr_ptr_q == rd_ptr_q);
    full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_s     = !empty_s && report_ready;
    push_ok_s = push_s && (!full_s || pop_s);
    drop_s    = push_s && full_s && !pop_s;
    ts_d      = ts_q + TS_WIDTH'(1);
    mem_d     = mem_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = {info_q, ts_q};
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clear) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (clear) begin
      event_count_d = push_s ? 16'd1 : 16'd0;
    end else if (push_s && (event_count_q != 16'hFFFF)) begin
      event_count_d = event_count_q + 16'd1;
    end else begin
      event_count_d = event_count_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q          <= {TS_WIDTH{1'b0}};
      wr_ptr_q      <= {(AW+1){1'b0}};
      rd_ptr_q      <= {(AW+1){1'b0}};
      overflow_q    <= 1'b0;
      event_count_q <= 16'd0;
    end else begin
      ts_q          <= ts_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      overflow_q    <= overflow_d;
      event_count_q <= event_count_d;
    end
  end

  // storage is never read while empty, so it needs no reset
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_hls_deadlock_report_collector.sv
// Scoreboard bench for hls_deadlock_report_collector (THRESHOLD=4, FIFO_DEPTH=4).
module tb_hls_deadlock_report_collector;
  localparam int THR   = 4;
  localparam int DEPTH = 4;
  localparam int TSW   = 32;

  logic            clock = 1'b0;
  logic            reset, block, report_ready, clear;
  logic [3:0]      info;
  logic            report_valid, deadlock_active, overflow;
  logic [4+TSW-1:0] report_data;
  logic [15:0]     event_count;

  hls_deadlock_report_collector #(.THRESHOLD(THR), .FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
    .clock(clock), .reset(reset), .block(block), .axis_block_info(info),
    .report_valid(report_valid), .report_ready(report_ready), .report_data(report_data),
    .deadlock_active(deadlock_active), .overflow(overflow), .event_count(event_count),
    .clear(clear)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;
  int n_pops  = 0;

  logic [35:0] exp_q[$];
  int          m_run;
  logic [3:0]  m_info;
  bit          m_conf, m_ovf;
  logic [15:0] m_ec;
  logic [31:0] m_ts;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: compare any handshake, advance the reference model, check outputs.
  task automatic step();
    bit cf;
    if (!reset) begin
      check_eq("valid_pre", 64'(report_valid), 64'(exp_q.size() != 0));
      if (report_ready && report_valid) begin
        n_pops++;
        if (exp_q.size() != 0) check_eq("pop_data", 64'(report_data), 64'(exp_q[0]));
      end
    end
    @(posedge clock);
    cf = 1'b0;
    if (reset) begin
      m_ts = 32'd0; m_run = 0; m_conf = 1'b0; m_ovf = 1'b0; m_ec = 16'd0;
      exp_q.delete();
    end else begin
      if (!block) begin
        m_run = 0; m_conf = 1'b0;
      end else if (!m_conf) begin
        if (m_run == 0 || info != m_info) begin
          m_run = 1; m_info = info;
        end else if (m_run == THR - 1) begin
          cf = 1'b1; m_conf = 1'b1; m_run = 0;
        end else begin
          m_run++;
        end
      end
      if (clear) begin m_ovf = 1'b0; m_ec = 16'd0; end
      if (report_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (cf) begin
        if (m_ec != 16'hFFFF) m_ec++;
        if (exp_q.size() < DEPTH) exp_q.push_back({m_info, m_ts});
        else m_ovf = 1'b1;
      end
      m_ts++;
    end
    #1;
    check_eq("valid", 64'(report_valid), 64'(exp_q.size() != 0));
    check_eq("active", 64'(deadlock_active), 64'(m_conf));
    check_eq("overflow", 64'(overflow), 64'(m_ovf));
    check_eq("event_count", 64'(event_count), 64'(m_ec));
    if (exp_q.size() != 0) check_eq("head", 64'(report_data), 64'(exp_q[0]));
    if (reset) check_eq("rst_data", 64'(report_data), 64'd0);
  endtask

  task automatic hold(input logic b, input logic [3:0] i, input int n);
    block = b; info = i;
    repeat (n) step();
  endtask

  task automatic episode(input logic [3:0] i);
    hold(1'b1, i, THR);
    hold(1'b0, 4'd0, 1);
  endtask

  task automatic drain(input int n);
    report_ready = 1'b1;
    repeat (n) step();
    report_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; block = 1'b0; info = 4'd0; report_ready = 1'b0; clear = 1'b0;
    repeat (2) step();
    reset = 1'b0;

    // First confirm: block from the edge where timestamp is 10
    hold(1'b0, 4'd0, 10);
    hold(1'b1, 4'hE, THR);
    check_eq("first_data", 64'(report_data), {28'd0, 4'hE, 32'd13});
    check_eq("first_valid", 64'(report_valid), 64'd1);
    check_eq("first_active", 64'(deadlock_active), 64'd1);
    check_eq("first_count", 64'(event_count), 64'd1);
    hold(1'b1, 4'h3, 3);
    check_eq("one_per_episode", 64'(event_count), 64'd1);
    hold(1'b0, 4'd0, 1);
    clear = 1'b1; step(); clear = 1'b0;
    drain(3);

    // Two short runs never confirm
    hold(1'b1, 4'h5, THR - 1);
    hold(1'b0, 4'h5, 1);
    hold(1'b1, 4'h5, THR - 1);
    hold(1'b0, 4'h5, 1);
    check_eq("short_count", 64'(event_count), 64'd0);
    check_eq("short_valid", 64'(report_valid), 64'd0);
    check_eq("short_active", 64'(deadlock_active), 64'd0);

    // Info change restarts the run
    hold(1'b1, 4'hE, 2);
    hold(1'b1, 4'hD, 3);
    check_eq("restart_pending", 64'(deadlock_active), 64'd0);
    hold(1'b1, 4'hD, 1);
    check_eq("restart_active", 64'(deadlock_active), 64'd1);
    check_eq("restart_info", 64'(report_data[35:32]), 64'hD);
    hold(1'b0, 4'd0, 1);
    drain(2);

    // Five episodes with no consumer: four kept, one lost
    for (int e = 0; e < 5; e++) episode(4'(e + 1));
    check_eq("ovf_set", 64'(overflow), 64'd1);
    clear = 1'b1; step(); clear = 1'b0;
    check_eq("ovf_clear", 64'(overflow), 64'd0);
    check_eq("count_clear", 64'(event_count), 64'd0);
    n_pops = 0;
    drain(8);
    check_eq("kept_four", 64'(n_pops), 64'd4);

    // Full FIFO: pop and push on the same edge
    for (int e = 0; e < 4; e++) episode(4'(e + 8));
    hold(1'b1, 4'hC, THR - 1);
    report_ready = 1'b1; step(); report_ready = 1'b0;
    check_eq("fullpop_ovf", 64'(overflow), 64'd0);
    hold(1'b0, 4'd0, 1);
    n_pops = 0;
    drain(8);
    check_eq("fullpop_occ", 64'(n_pops), 64'd4);

    // Reset mid-run and while confirmed
    hold(1'b1, 4'h7, 2);
    reset = 1'b1; clear = 1'b1; report_ready = 1'b1; step();
    reset = 1'b0; clear = 1'b0; report_ready = 1'b0;
    check_eq("rst1_active", 64'(deadlock_active), 64'd0);
    check_eq("rst1_valid", 64'(report_valid), 64'd0);
    hold(1'b1, 4'h7, THR + 1);
    reset = 1'b1; step(); reset = 1'b0;
    check_eq("rst2_active", 64'(deadlock_active), 64'd0);
    check_eq("rst2_count", 64'(event_count), 64'd0);
    check_eq("rst2_valid", 64'(report_valid), 64'd0);
    hold(1'b0, 4'd0, 1);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      block = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) info = 4'($urandom_range(0, 15));
      report_ready = ($urandom_range(0, 2) == 0);
      clear = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; clear = 1'b0; block = 1'b0;
    drain(8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
